fpu_pipe_sched: RTL
===================

// Module: fpu_pipe_sched
// PURPOSE
//  Issue scheduler and stage-enable controller for the pipelined FP multiply unit.
//  Arbitrates two requesters (0 = main thread, 1 = interrupt context) round-robin into stage 0.
//  Drives per-stage register enables (e) with bubble collapse, and tracks {valid,id,tag} per stage.
//  Presents results through a valid/ready port and supports flushing requester-0 work on interrupt entry.
// PARAMETERS
//  STAGES  3  number of pipeline registers (input reg, mul->add reg, add->norm reg)
//  TAG_W   5  destination-register tag width carried alongside each op
// PORTS
//  clk         in   1       clock, rising edge
//  clrn        in   1       asynchronous active-low reset
//  req0_valid  in   1       requester 0 has an op
//  req0_tag    in   TAG_W   requester 0 destination tag
//  req0_ready  out  1       requester 0 op accepted this cycle
//  req1_valid  in   1       requester 1 has an op
//  req1_tag    in   TAG_W   requester 1 destination tag
//  req1_ready  out  1       requester 1 op accepted this cycle
//  flush0      in   1       kill all in-flight requester-0 ops (1-cycle pulse)
//  issue_sel   out  1       operand mux select into stage 0 (requester id)
//  stage_en    out  STAGES  enable for pipeline register k (drives e of each stage reg)
//  res_valid   out  1       result at last stage is valid
//  res_id      out  1       requester id of result
//  res_tag     out  TAG_W   destination tag of result
//  res_ready   in   1       consumer accepts result
//  busy0       out  1       any requester-0 op in flight
//  busy1       out  1       any requester-1 op in flight
// BEHAVIOUR
//  Reset (clrn=0, async): all slot valids 0, ids/tags 0, last_grant=1.
//   Outputs after reset: res_valid=0, busy0=busy1=0, stage_en=all 1.
//  Slots 0..STAGES-1, each holding {v,id,tag}; slot STAGES-1 drives res_*.
//  Load chain (combinational):
//   ld[STAGES] = res_ready; ld[k] = !v[k] | ld[k+1]; stage_en[k] = ld[k].
//  On edge, for each k with ld[k]=1: slot k <= slot k-1; slot 0 <= {issue_fire, grant, granted tag}.
//   Slots with ld[k]=0 hold. Bubbles collapse; back-pressure propagates with zero added latency.
//  Latency: an accepted op reaches res_valid exactly STAGES cycles later if never stalled.
//  Arbitration (round-robin, 2-way):
//   Both valid -> grant = !last_grant; one valid -> that one; none -> issue_sel = last_grant.
//   reqN_ready = stage_en[0] & grant==N & reqN_valid & !(N==0 & flush0).
//   issue_fire = req0_ready | req1_ready; last_grant <= grant only when issue_fire.
//  Output handshake:
//   res_valid = v[last] & !(flush0 & id[last]==0). Transfer occurs when res_valid & res_ready.
//   res_id/res_tag are stable while res_valid=1 and res_ready=0.
//  Flush:
//   flush0=1 clears v of every slot whose id==0, including the value shifting into it that edge.
//   Flush overrides advance. Requester-1 ops are unaffected and keep order.
//   req0 issue is blocked in the flush cycle; req1 may issue in the same cycle.
//  Simultaneous events:
//   Pop at output plus issue at stage 0 in one cycle is allowed (full pipe sustains 1 op/cycle).
//   flush0 with res_ready: a flushed id-0 head is dropped, never handshaken.
//  busyN = OR over k of (v[k] & id[k]==N), registered-slot based.
//  Reset mid-operation discards all in-flight state; the datapath regs share clrn.
// STRUCTURE
//  fpu_pipe_defs.vh: REQ_MAIN=1'b0, REQ_IRQ=1'b1, default STAGES/TAG_W.
//  Sub-module rr_arb2: 2-way round-robin arbiter with last_grant register and update enable.
//  Slot array and load chain live in the top; no datapath bits pass through this block.
// TESTING
//  1. Reset, single req0 op tag=5, res_ready=1 -> res_valid at cycle+3, res_id=0, res_tag=5, busy0 back to 0.
//  2. req0 and req1 both valid for 6 cycles -> grants alternate 0,1,0,1,0,1; results emerge in that order.
//  3. Fill pipe (3 ops), hold res_ready=0 -> stage_en=000, req*_ready=0, res_tag stable;
//     release -> one pop per cycle, no loss.
//  4. Bubble: ops at slots 0 and 2 only, res_ready=0 -> stage_en=011, both ops end adjacent in slots 1,2.
//  5. Pipe holds id 0,1,0; pulse flush0 with res_ready=1 and req1 issuing tag=9
//     -> only id-1 op and tag 9 emerge; busy0=0 next cycle.
//  6. Assert clrn low mid-stream with res_valid=1 -> res_valid=0 immediately (async),
//     stage_en=111 after release, first op granted to req0.

Source files
------------

// File: rtl/fpu_pipe_sched_pkg.sv
// Shared constants and the round-robin pick rule for the FP multiply issue scheduler.
package fpu_pipe_sched_pkg;

  localparam int STAGES_DEF = 3;
  localparam int TAG_W_DEF  = 5;

  localparam logic REQ_MAIN = 1'b0;
  localparam logic REQ_IRQ  = 1'b1;

  typedef enum logic {
    GNT_MAIN = 1'b0,
    GNT_IRQ  = 1'b1
  } gnt_e;

  // Both requesting -> alternate; one requesting -> that one; idle -> park on last winner.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    logic g;
    g = last;
    if (v0 && v1)  g = ~last;
    else if (v0)   g = REQ_MAIN;
    else if (v1)   g = REQ_IRQ;
    return g;
  endfunction

endpackage

// File: rtl/fpu_pipe_sched_rr_arb2.sv
// Two-way round-robin arbiter; last_grant only moves when an issue actually happens.
module rr_arb2
  import fpu_pipe_sched_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [1:0] req_valid,
  input  logic       upd,
  output logic       grant
);

  logic last_grant;

  assign grant = rr_pick(req_valid[0], req_valid[1], last_grant);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)    last_grant <= REQ_IRQ;
    else if (upd) last_grant <= grant;
  end

endmodule

// File: rtl/fpu_pipe_sched.sv
// Issue scheduler and stage-enable controller for the pipelined FP multiplier:
// tracks {valid,id,tag} per pipeline register, collapses bubbles, flushes main-thread work.
module fpu_pipe_sched
  import fpu_pipe_sched_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              req0_valid,
  input  logic [TAG_W-1:0]  req0_tag,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              req1_ready,
  input  logic              flush0,
  output logic              issue_sel,
  output logic [STAGES-1:0] stage_en,
  output logic              res_valid,
  output logic              res_id,
  output logic [TAG_W-1:0]  res_tag,
  input  logic              res_ready,
  output logic              busy0,
  output logic              busy1
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] id;
  logic [TAG_W-1:0]  tag [STAGES];
  logic [STAGES-1:0] ld;
  logic              grant;
  logic              issue_fire;
  logic [TAG_W-1:0]  in_tag;

  // A slot may load if it is empty or everything downstream of it is moving.
  always_comb begin
    logic acc;
    acc = res_ready;
    ld  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc   = ~v[k] | acc;
      ld[k] = acc;
    end
  end

  assign stage_en = ld;

  rr_arb2 u_arb (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid ({req1_valid, req0_valid}),
    .upd       (issue_fire),
    .grant     (grant)
  );

  assign issue_sel  = grant;
  assign req0_ready = ld[0] & (grant == REQ_MAIN) & req0_valid & ~flush0;
  assign req1_ready = ld[0] & (grant == REQ_IRQ)  & req1_valid;
  assign issue_fire = req0_ready | req1_ready;
  assign in_tag     = (grant == REQ_IRQ) ? req1_tag : req0_tag;

  // Flush masks whatever value each slot ends up holding, shifted-in or held.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v  <= '0;
      id <= '0;
      for (int k = 0; k < STAGES; k++) tag[k] <= '0;
    end else begin
      if (ld[0]) begin
        v[0]   <= issue_fire & ~(flush0 & (grant == REQ_MAIN));
        id[0]  <= grant;
        tag[0] <= in_tag;
      end else begin
        v[0]   <= v[0] & ~(flush0 & (id[0] == REQ_MAIN));
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k]   <= v[k-1] & ~(flush0 & (id[k-1] == REQ_MAIN));
          id[k]  <= id[k-1];
          tag[k] <= tag[k-1];
        end else begin
          v[k]   <= v[k] & ~(flush0 & (id[k] == REQ_MAIN));
        end
      end
    end
  end

  assign res_valid = v[STAGES-1] & ~(flush0 & (id[STAGES-1] == REQ_MAIN));
  assign res_id    = id[STAGES-1];
  assign res_tag   = tag[STAGES-1];

  assign busy0 = |(v & ~id);
  assign busy1 = |(v & id);

endmodule
